// File: rtl/poolchan_stream.sv
// poolchan_stream
// Streaming binary pooling stage. One image row per beat arrives for all
// channels in parallel. Each POOLxPOOL window is reduced with a runtime
// mode (OR, AND, majority). One pooled row leaves per POOL input rows over a
// valid/ready handshake that supports backpressure.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   i_mode   00 OR, 01 AND, 10 majority, 11 reserved (behaves as OR)
//   i_valid  input row valid
//   o_ready  input row can be accepted
//   i_row    input row, channel c column j at index c*IMG_W+j
//   o_valid  pooled row valid
//   i_ready  downstream can take the pooled row
//   o_row    pooled row, channel c column k at index c*(IMG_W/POOL)+k
//   o_last   o_row is the final pooled row of the frame
//
// The accumulators, output register and handshake form a simple datapath with
// no FSM. The only sequencing state is the frame row counter.
module poolchan_stream #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int CHANNELS = 2,
    parameter int POOL     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         i_mode,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [0:CHANNELS*IMG_W-1]          i_row,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [0:CHANNELS*(IMG_W/POOL)-1]   o_row,
    output logic                               o_last
);

    localparam int OUT_W = IMG_W / POOL;
    localparam int N_WIN = CHANNELS * OUT_W;
    localparam int AW    = $clog2(POOL * POOL + 1);
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW    = $clog2(POOL);

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_MAJ = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    logic [RW-1:0]      row_cnt_q, row_cnt_d;
    mode_e              mode_q, mode_d;
    logic [AW-1:0]      acc_q [N_WIN];
    logic [AW-1:0]      acc_d [N_WIN];
    logic [AW-1:0]      win_cnt [N_WIN];
    logic               o_valid_q, o_valid_d;
    logic               o_last_q, o_last_d;
    logic [0:N_WIN-1]   o_row_q, o_row_d;
    logic [0:N_WIN-1]   red;

    logic               accept;
    logic               xfer;
    logic [PW-1:0]      sub_cnt;
    logic               group_first;
    logic               group_last;
    logic               frame_last;

    // Accept whenever the output register is empty or drains this cycle.
    assign o_ready = !(o_valid_q && !i_ready);
    assign accept  = i_valid && o_ready;
    assign xfer    = o_valid_q && i_ready;

    // POOL is a power of two, so the low bits of the row counter are the
    // position inside the current group.
    assign sub_cnt     = row_cnt_q[PW-1:0];
    assign group_first = (sub_cnt == '0);
    assign group_last  = (sub_cnt == PW'(POOL - 1));
    assign frame_last  = (row_cnt_q == RW'(IMG_H - 1));

    always_comb begin
        row_cnt_d = row_cnt_q;
        mode_d    = mode_q;
        o_valid_d = o_valid_q;
        o_last_d  = o_last_q;
        o_row_d   = o_row_q;
        red       = '0;

        for (int w = 0; w < N_WIN; w++) begin
            win_cnt[w] = '0;
            for (int b = 0; b < POOL; b++) begin
                win_cnt[w] = win_cnt[w]
                           + AW'(i_row[(w / OUT_W) * IMG_W + (w % OUT_W) * POOL + b]);
            end
            acc_d[w] = acc_q[w];
        end

        if (accept) begin
            row_cnt_d = frame_last ? '0 : row_cnt_q + RW'(1);
            if (row_cnt_q == '0) begin
                mode_d = mode_e'(i_mode);
            end
            for (int w = 0; w < N_WIN; w++) begin
                acc_d[w] = (group_first ? '0 : acc_q[w]) + win_cnt[w];
            end
        end

        // mode_q is safe to use here: a group never ends on row 0, so the
        // frame's mode was latched on an earlier beat.
        for (int w = 0; w < N_WIN; w++) begin
            case (mode_q)
                MODE_AND: red[w] = (acc_d[w] == AW'(POOL * POOL));
                MODE_MAJ: red[w] = (acc_d[w] >= AW'(POOL * POOL / 2));
                default:  red[w] = (acc_d[w] != '0);
            endcase
        end

        if (xfer) begin
            o_valid_d = 1'b0;
            o_last_d  = 1'b0;
        end

        // A completing group overrides the drain so rows can go back-to-back.
        if (accept && group_last) begin
            o_valid_d = 1'b1;
            o_last_d  = frame_last;
            o_row_d   = red;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt_q <= '0;
            mode_q    <= MODE_OR;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_row_q   <= '0;
            for (int w = 0; w < N_WIN; w++) begin
                acc_q[w] <= '0;
            end
        end else begin
            row_cnt_q <= row_cnt_d;
            mode_q    <= mode_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            o_row_q   <= o_row_d;
            for (int w = 0; w < N_WIN; w++) begin
                acc_q[w] <= acc_d[w];
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_row   = o_row_q;

endmodule

// File: doc/poolchan_stream.md
Name: poolchan_stream

Overview:
- Parametrised streaming binary pooling stage. Successor to the fixed 8x8, single-channel, OR-only 2x2 pooler.
- Accepts one image row per beat for all channels in parallel and reduces each POOLxPOOL window with a runtime-selectable mode (OR, AND, majority).
- Emits one pooled row per POOL input rows over a valid/ready handshake with backpressure.
- Sits between the binarised conv/activation stage and the next conv layer's row buffer.

Parameters:
- IMG_W, 8, input row width in pixels per channel; must be a multiple of POOL.
- IMG_H, 8, input rows per frame; must be a multiple of POOL.
- CHANNELS, 2, number of independent channels processed in parallel.
- POOL, 2, square window side and stride; legal values are 2 and 4.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- i_mode  in  2  pooling mode: 00 OR, 01 AND, 10 majority, 11 reserved (treated as OR).
- i_valid  in  1  input row valid.
- o_ready  out  1  block can accept an input row.
- i_row  in  CHANNELS*IMG_W  input row, ascending [0:N-1]; channel c, column j at index c*IMG_W+j.
- o_valid  out  1  pooled row valid.
- i_ready  in  1  downstream can accept the pooled row.
- o_row  out  CHANNELS*IMG_W/POOL  pooled row; channel c, column k at index c*(IMG_W/POOL)+k.
- o_last  out  1  qualifies o_row as the final pooled row of the frame.

Behaviour:
- Input accept: when i_valid && o_ready. Output transfer: when o_valid && i_ready.
- o_ready = !(o_valid && !i_ready). The block accepts input whenever its output register is empty or is draining this cycle.
- row_cnt counts 0..IMG_H-1 on each accept, then wraps to 0. sub_cnt = row_cnt mod POOL.
- Per channel and per output column, a popcount accumulator of width clog2(POOL*POOL+1) adds the POOL bits of its window from the accepted row.
- On the accept with sub_cnt==0, the accumulator is loaded rather than added.
- Reduction, evaluated on the accept with sub_cnt==POOL-1, using count = final accumulated value:
  - OR: count != 0.
  - AND: count == POOL*POOL.
  - Majority: count >= POOL*POOL/2. This means >=2 for POOL=2 and >=8 for POOL=4; ties resolve to 1.
- Latency: o_row, o_valid and o_last are registered. o_valid rises the cycle after the accept of the last row in a group.
- o_last = 1 when that group ends at row_cnt==IMG_H-1.
- o_valid stays high and o_row/o_last stay stable until the output transfer.
- o_valid clears after the transfer unless a new group completes in the same cycle, in which case the new data loads back-to-back.
- Mode is latched into mode_q on the accept with row_cnt==0. Changes to i_mode during the rest of the frame have no effect until the next frame start.
- Input beats while o_ready=0 are not consumed; the upstream holds them.
- Reset values:
  - o_valid=0, o_last=0, o_row=all 0.
  - row_cnt=0, accumulators=0, mode_q=OR.
  - o_ready=1 in the cycle after reset deasserts.
- Reset mid-frame discards partial groups and any pending output. The next accepted row is row 0 of a new frame.
- An ungated reduction or partial-group output is never emitted.

Test Plan (defaults IMG_W=8, IMG_H=8, CHANNELS=2, POOL=2; rows written left to right as index 0..7):
- OR mode; ch0 row0=10000000, row1=00000001; ch1 all zeros -> one cycle after the row1 accept: o_valid=1, o_row ch0=1001, ch1=0000, o_last=0.
- AND mode; ch0 row0=11000011, row1=11000010; ch1 both rows all ones -> o_row ch0=1000, ch1=1111.
- Majority mode; ch0 row0=10100000, row1=10010000 -> ch0=1100. Window (1,0,0,0) yields 0.
- Backpressure: hold i_ready=0 when the row1 group completes.
  - Required: o_valid held and o_row stable for 5 cycles; o_ready=0 and a presented row2 is not consumed.
  - Raise i_ready: the output transfers, then row2 is accepted.
- Full frame: 8 rows streamed back-to-back with i_ready=1 -> exactly 4 o_valid pulses, o_last=1 only on the 4th.
  - i_mode switched from OR to AND after row3 -> all 4 outputs are OR-reduced; the next frame uses AND.
- Reset mid-frame: accept row0=11111111, assert rst one cycle, then stream row0=00000000 and row1=00000000 in OR mode.
  - Required: o_row=0000 for both channels, no output before the new row1, and o_valid=0 during and right after reset.
